// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Bundles everything the SRAM arbiter exchanges with its two requesters and
// with the single-port SRAM.
//   req0_* / req1_*  : access request handshake (valid/ready), write flag,
//                      address, write data, lock hint
//   rsp0_valid/rsp1_valid, rsp_data : read response pulse and shared data
//   sram_*           : registered SRAM control, write data and read data return
// Modports:
//   slave  : the arbiter side
//   master : the requester/SRAM environment side
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_write;
  logic [ADDR_WIDTH-1:0] req0_address;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  req0_lock;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_write;
  logic [ADDR_WIDTH-1:0] req1_address;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  req1_lock;

  logic                  rsp0_valid;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  logic [ADDR_WIDTH-1:0] sram_address;
  logic [DATA_WIDTH-1:0] sram_write_data;
  logic                  sram_enable;
  logic                  sram_write;
  logic [DATA_WIDTH-1:0] sram_read_data;

  modport slave (
    input  req0_valid, req0_write, req0_address, req0_wdata, req0_lock,
    input  req1_valid, req1_write, req1_address, req1_wdata, req1_lock,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    output sram_address, sram_write_data, sram_enable, sram_write,
    input  sram_read_data
  );

  modport master (
    output req0_valid, req0_write, req0_address, req0_wdata, req0_lock,
    output req1_valid, req1_write, req1_address, req1_wdata, req1_lock,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    input  sram_address, sram_write_data, sram_enable, sram_write,
    output sram_read_data
  );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Two-requester round-robin arbiter and access sequencer in front of a
// single-port SRAM. One access is accepted per cycle; the winning request is
// registered onto the SRAM pins (issue stage) and, for reads, the SRAM output
// is registered into rsp_data one cycle later with a one-cycle rspN_valid
// pulse to the owner (capture stage). Read latency is 2 cycles.
//
// Ports:
//   clock    : rising-edge clock
//   reset_b  : asynchronous active-low reset
//   bus      : sram_arbiter_if.slave (requests, responses, SRAM pins)
//
// Optional feature macro: SRAM_ARB_LOCK_EN
//   defined   : reqN_lock lets the current holder keep the grant for up to
//               LOCK_MAX consecutive beats
//   undefined : lock inputs are ignored, pure round-robin
// -----------------------------------------------------------------------------
module sram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LOCK_MAX   = 4
) (
  input  logic            clock,
  input  logic            reset_b,
  sram_arbiter_if.slave   bus
);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  lock;
  } req_t;

  req_t       req0;
  req_t       req1;
  req_t       sel;
  logic [1:0] valid;
  logic       last_grant;
  logic       grant_any;
  logic       grant_id;
  logic       hold;
  logic       issue_owner;

  assign req0  = '{write: bus.req0_write, address: bus.req0_address,
                   wdata: bus.req0_wdata, lock: bus.req0_lock};
  assign req1  = '{write: bus.req1_write, address: bus.req1_address,
                   wdata: bus.req1_wdata, lock: bus.req1_lock};
  assign valid = {bus.req1_valid, bus.req0_valid};

  // Grant selection. A held lock wins outright; otherwise a tie goes to the
  // requester that did not win last, and a single valid simply wins.
  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    grant_any = |valid;
    grant_id  = 1'b0;
    if (hold) begin
      grant_id = last_grant;
    end else if (&valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = valid[1];
    end
  end

  assign sel = grant_id ? req1 : req0;

  // Ready is gated by reset_b so all outputs read 0 while reset is held.
  assign bus.req0_ready = reset_b & grant_any & ~grant_id;
  assign bus.req1_ready = reset_b & grant_any &  grant_id;

`ifdef SRAM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  // beat_cnt != 0 means the last beat was a locked transfer by last_grant and
  // the holder may take another one. It counts beats already taken and wraps
  // to 0 when LOCK_MAX is reached, which releases the lock.
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_cnt_next;

  assign hold = (beat_cnt != '0) && valid[last_grant];

  always_comb begin
    beat_cnt_next = '0;
    if (grant_any && sel.lock) begin
      beat_cnt_next = hold ? beat_cnt + 1'b1 : CW'(1);
      if (beat_cnt_next == CW'(LOCK_MAX)) begin
        beat_cnt_next = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      beat_cnt <= '0;
    end else begin
      beat_cnt <= beat_cnt_next;
    end
  end
`else
  assign hold = 1'b0;

  logic unused_lock;
  assign unused_lock = &{1'b0, sel.lock, (LOCK_MAX > 0)};
`endif

  // Issue stage: register the winner onto the SRAM pins. Address and write
  // data hold their last value when idle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      bus.sram_address    <= '0;
      bus.sram_write_data <= '0;
      bus.sram_enable     <= 1'b0;
      bus.sram_write      <= 1'b0;
      issue_owner         <= 1'b0;
      last_grant          <= 1'b1;
    end else if (grant_any) begin
      bus.sram_address    <= sel.address;
      bus.sram_write_data <= sel.wdata;
      bus.sram_enable     <= 1'b1;
      bus.sram_write      <= sel.write;
      issue_owner         <= grant_id;
      last_grant          <= grant_id;
    end else begin
      bus.sram_enable     <= 1'b0;
      bus.sram_write      <= 1'b0;
    end
  end

  // Capture stage: a read on the pins this cycle is sampled at the closing
  // edge, giving the owner a one-cycle response pulse.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      bus.rsp_data   <= '0;
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
    end else if (bus.sram_enable && !bus.sram_write) begin
      bus.rsp_data   <= bus.sram_read_data;
      bus.rsp0_valid <= ~issue_owner;
      bus.rsp1_valid <=  issue_owner;
    end else begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
    end
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter and access sequencer for the single-port generic SRAM. Two requesters, for example the weight-fetch engine and the result-writeback engine, share one SRAM at one access per cycle. The block issues registered SRAM control and captures read data. Read responses return to the owning requester after a fixed latency.

## Interface
Parameters:
- ADDR_WIDTH, 8, SRAM address width
- DATA_WIDTH, 16, SRAM data width
- LOCK_MAX, 4, maximum consecutive beats one requester may hold via lock (≥1)

Ports:
- clock  in  1  single clock; all state changes on the rising edge
- reset_b  in  1  asynchronous, active-low reset
- reqN_valid  in  1  requester N (N=0,1) has an access pending
- reqN_ready  out  1  requester N's access is accepted this cycle (combinational)
- reqN_write  in  1  1 = write, 0 = read
- reqN_address  in  ADDR_WIDTH  access address
- reqN_wdata  in  DATA_WIDTH  write data
- reqN_lock  in  1  request to keep the grant on the next beat
- rspN_valid  out  1  one-cycle pulse: rsp_data holds requester N's read result
- rsp_data  out  DATA_WIDTH  read data, shared by both requesters
- sram_address  out  ADDR_WIDTH  to SRAM address
- sram_write_data  out  DATA_WIDTH  to SRAM write_data
- sram_enable  out  1  to SRAM enable
- sram_write  out  1  to SRAM write
- sram_read_data  in  DATA_WIDTH  from SRAM read_data

## Operation
- Transfer: reqN_valid & reqN_ready in the same cycle. At most one ready is high per cycle. Ready never asserts without the matching valid.
- Arbitration, only one valid: that requester is granted.
- Arbitration, both valid: the requester not granted most recently wins. Pointer last_grant updates only on a transfer. After reset last_grant=1, so req0 wins the first tie.
- Lock (macro-dependent, see Configuration): the holder keeps the grant while its valid stays high. The lock is released when lock deasserts, valid drops, or the beat counter reaches LOCK_MAX. On release the other requester wins the next tie.
- Issue stage: on a transfer, the address, wdata, write flag and owner ID are registered to the SRAM outputs, with sram_enable=1. No transfer: sram_enable=0 and sram_write=0; sram_address and sram_write_data hold their last value.
- Capture stage: for a read in flight, sram_read_data is registered into rsp_data and rsp{owner}_valid pulses. rsp_data holds its value until the next read capture.
- Writes produce no response.
- Reset (any time, async): all outputs 0, last_grant=1, lock counter 0. In-flight accesses are discarded and no response is issued. sram_enable drops immediately, without waiting for a clock edge.

## Timing
- Transfer in cycle T: SRAM pins are valid in T+1.
- Write: commits at the rising edge that ends T+1.
- Read: captured at the edge ending T+1; rspN_valid and rsp_data are valid in T+2. Latency is 2.
- Throughput: one access per cycle. Back-to-back reads give back-to-back response pulses.
- Read-after-write to the same address: write accepted in T, read accepted in T+1. The read returns the new data in T+3 with no hazard logic needed.
- The SRAM read path is combinational with a sub-cycle delay. The capture register samples at the end of the enable cycle, so the minimum clock period must exceed the SRAM read delay.
- reqN_ready depends combinationally on both valids, last_grant and lock state. It must not depend on ready or response outputs.

## Configuration
- SRAM_ARB_LOCK_EN defined: the lock behaviour above is active and LOCK_MAX is enforced by a beat counter that resets on release.
- SRAM_ARB_LOCK_EN undefined: reqN_lock ports remain but are ignored. The lock counter is not built and arbitration is pure round-robin.

## Test plan
- Reset: assert reset_b=0 mid-read, two cycles after a transfer -> all outputs 0 immediately and no rsp pulse after release. The first tie after release goes to req0.
- Single read: req0 writes 0xBEEF to addr 0x12 in cycle T; req0 reads 0x12 in T+1 -> rsp0_valid=1 with rsp_data=0xBEEF in T+3; rsp1_valid stays 0.
- Tie, round-robin: both valid and reading continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; rsp pulses alternate accordingly, 2 cycles after each grant.
- Idle hold: a transfer to addr 0x34, then 3 idle cycles -> sram_enable=0 and sram_write=0 for those cycles; sram_address stays 0x34.
- Lock, with SRAM_ARB_LOCK_EN and LOCK_MAX=4: req0 valid+lock and req1 valid continuously -> req0 gets 4 beats, then req1 gets 1, then req0 gets 4.
- Lock, without the macro: same stimulus -> strict alternation.
- Write then read, cross-requester: req1 writes 0x00A5 to addr 0xFF in T; req0 reads 0xFF in T+1 -> rsp0_valid and rsp_data=0x00A5 in T+3.
